// File: rtl/oserdes_mem_burst_if.sv
// Write-data stream between the write-data FIFO and the burst formatter.
// Latency: none, wires only.
// Backpressure: wr_ready from the formatter; a beat moves when wr_valid & wr_ready.
interface oserdes_mem_burst_if #(
    parameter int NLANES = 8
);
    logic [NLANES*4-1:0] wr_data;
    logic                wr_valid;
    logic                wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/oserdes_mem_burst.sv
// Burst formatter: stream beats -> per-lane 4-bit din/tin nibbles with driven pre/postamble.
// Latency: start to first data nibble on din_o is PRE_CYCLES+1 cycles; outputs one cycle behind state.
// Backpressure: wr_ready high only in DATA; stalls drive zeros and set sticky underrun.
// Optional strobe lane (dqs_din_o/dqs_tin_o) is built when OSERDES_MEM_BURST_DQS_EN is defined.
module oserdes_mem_burst #(
    parameter int NLANES      = 8,
    parameter int LEN_W       = 6,
    parameter int PRE_CYCLES  = 1,
    parameter int POST_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [LEN_W-1:0]    burst_len_i,
    oserdes_mem_burst_if.slave  wr_if,
    output logic [NLANES*4-1:0] din_o,
    output logic [NLANES*4-1:0] tin_o,
    output logic                busy_o,
    output logic                done_o,
`ifdef OSERDES_MEM_BURST_DQS_EN
    output logic [3:0]          dqs_din_o,
    output logic [3:0]          dqs_tin_o,
`endif
    output logic                underrun_o
);
    localparam int          DW      = NLANES * 4;
    localparam int          CNT_W   = LEN_W + 1;
    localparam logic [3:0]  PRE_LD  = 4'(PRE_CYCLES - 1);
    localparam logic [3:0]  POST_LD = 4'(POST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_POST
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic [3:0]          phase_q;
    logic                fin_q;      // POST just ended; done fires with the tin release
    logic [DW-1:0]       din_q;
    logic [DW-1:0]       tin_q;
    logic                done_q;
    logic                underrun_q;
`ifdef OSERDES_MEM_BURST_DQS_EN
    logic [3:0]          dqs_din_q;
    logic [3:0]          dqs_tin_q;
`endif

    logic [CNT_W-1:0]    beat_ld_d;

    // A zero length request means the full 2**LEN_W beats.
    assign beat_ld_d = (burst_len_i == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, burst_len_i};

    assign wr_if.wr_ready = (state_q == S_DATA);
    assign busy_o         = (state_q != S_IDLE);
    assign din_o          = din_q;
    assign tin_o          = tin_q;
    assign done_o         = done_q;
    assign underrun_o     = underrun_q;
`ifdef OSERDES_MEM_BURST_DQS_EN
    assign dqs_din_o      = dqs_din_q;
    assign dqs_tin_o      = dqs_tin_q;
`endif

    // Burst FSM with registered lane outputs derived from the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            phase_q    <= '0;
            fin_q      <= 1'b0;
            din_q      <= '0;
            tin_q      <= '1;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef OSERDES_MEM_BURST_DQS_EN
            dqs_din_q  <= 4'b0000;
            dqs_tin_q  <= 4'b1111;
`endif
        end else begin
            done_q <= fin_q;
            fin_q  <= 1'b0;
            din_q  <= '0;
            tin_q  <= '0;
`ifdef OSERDES_MEM_BURST_DQS_EN
            dqs_din_q <= 4'b0000;
            dqs_tin_q <= 4'b0000;
`endif
            case (state_q)
                S_IDLE: begin
                    tin_q <= '1;
`ifdef OSERDES_MEM_BURST_DQS_EN
                    dqs_tin_q <= 4'b1111;
`endif
                    if (start_i) begin
                        beat_cnt_q <= beat_ld_d;
                        phase_q    <= PRE_LD;
                        underrun_q <= 1'b0;
                        state_q    <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (phase_q == 4'd0) begin
                        state_q <= S_DATA;
                    end else begin
                        phase_q <= phase_q - 4'd1;
                    end
                end
                S_DATA: begin
`ifdef OSERDES_MEM_BURST_DQS_EN
                    // Strobe toggles whether or not a beat moves; D1 (bit 0) is low.
                    dqs_din_q <= 4'b1010;
`endif
                    if (wr_if.wr_valid) begin
                        din_q      <= wr_if.wr_data;
                        beat_cnt_q <= beat_cnt_q - CNT_W'(1);
                        if (beat_cnt_q == CNT_W'(1)) begin
                            phase_q <= POST_LD;
                            state_q <= S_POST;
                        end
                    end else begin
                        underrun_q <= 1'b1;
                    end
                end
                S_POST: begin
                    if (phase_q == 4'd0) begin
                        fin_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        phase_q <= phase_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oserdes_mem_burst.sv
// Directed bench for oserdes_mem_burst: reset, nominal, stall, wrap, mid-burst reset, strobe lane.
// Latency: expected tables are indexed by the edge number counted from the start edge.
// Backpressure: wr_valid patterns per edge emulate the write-data FIFO running dry.
module tb_oserdes_mem_burst;
    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  burst_len;
    logic [31:0] din;
    logic [31:0] tin;
    logic        busy;
    logic        done;
    logic        underrun;
`ifdef OSERDES_MEM_BURST_DQS_EN
    logic [3:0]  dqs_din;
    logic [3:0]  dqs_tin;
`endif

    oserdes_mem_burst_if #(.NLANES(8)) wr_if ();

    oserdes_mem_burst #(
        .NLANES(8), .LEN_W(6), .PRE_CYCLES(1), .POST_CYCLES(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .burst_len_i(burst_len),
        .wr_if      (wr_if.slave),
        .din_o      (din),
        .tin_o      (tin),
        .busy_o     (busy),
        .done_o     (done),
`ifdef OSERDES_MEM_BURST_DQS_EN
        .dqs_din_o  (dqs_din),
        .dqs_tin_o  (dqs_tin),
`endif
        .underrun_o (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc;

    logic [0:79] st_pat;
    logic [0:79] vld_pat;

    logic [31:0] r_din  [0:79];
    logic [31:0] r_tin  [0:79];
    logic        r_done [0:79];
    logic        r_rdy  [0:79];
    logic        r_busy [0:79];
    logic        r_und  [0:79];
`ifdef OSERDES_MEM_BURST_DQS_EN
    logic [3:0]  r_qdin [0:79];
    logic [3:0]  r_qtin [0:79];
`endif

    // Nominal burst, len 4: outputs after edge k (k=0 is the start edge).
    logic [31:0] nom_din [0:8] = '{32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333,
                                   32'h44444444, 32'h0, 32'h0, 32'h0};
    logic [31:0] nom_tin [0:8] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'hFFFFFFFF, 32'hFFFFFFFF};
    logic        nom_done[0:8] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic        nom_rdy [0:8] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};

    // Stall burst, len 2, valid low on edges 3..5.
    logic [31:0] stl_din [0:9] = '{32'h0, 32'h0, 32'h11111111, 32'h0, 32'h0, 32'h0,
                                   32'h22222222, 32'h0, 32'h0, 32'h0};
    logic [31:0] stl_tin [0:9] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic        stl_done[0:9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dat_fn(input int i);
        return 32'(32'h1111_1111 * (i + 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n edges from the start/valid patterns and records outputs after each edge.
    task automatic run(input int n);
        int  idx;
        logic acc;
        idx   = 0;
        n_acc = 0;
        for (int k = 0; k < n; k++) begin
            start          = st_pat[k];
            wr_if.wr_valid = vld_pat[k];
            wr_if.wr_data  = vld_pat[k] ? dat_fn(idx) : 32'hDEADBEEF;
            acc            = wr_if.wr_valid && wr_if.wr_ready;
            tick();
            if (acc) begin
                idx++;
                n_acc++;
            end
            r_din[k]  = din;
            r_tin[k]  = tin;
            r_done[k] = done;
            r_rdy[k]  = wr_if.wr_ready;
            r_busy[k] = busy;
            r_und[k]  = underrun;
`ifdef OSERDES_MEM_BURST_DQS_EN
            r_qdin[k] = dqs_din;
            r_qtin[k] = dqs_tin;
`endif
        end
        start          = 1'b0;
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic set_pats(input int first_stall, input int n_stall);
        st_pat    = '0;
        st_pat[0] = 1'b1;
        vld_pat   = '1;
        for (int k = first_stall; k < first_stall + n_stall; k++) vld_pat[k] = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        burst_len      = '0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;

        // Reset state
        tick();
        tick();
        check("rst_din", din, 32'h0);
        check("rst_tin", tin, 32'hFFFFFFFF);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_und", underrun, 0);
        rst = 1'b0;
        tick();

        // Nominal burst of 4
        burst_len = 6'd4;
        set_pats(0, 0);
        run(9);
        check("nom_busy0", r_busy[0], 1);
        for (int k = 1; k < 9; k++) begin
            check($sformatf("nom_din%0d", k), r_din[k], nom_din[k]);
            check($sformatf("nom_tin%0d", k), r_tin[k], nom_tin[k]);
            check($sformatf("nom_done%0d", k), r_done[k], nom_done[k]);
            check($sformatf("nom_rdy%0d", k), r_rdy[k], nom_rdy[k]);
        end
        check("nom_acc", n_acc, 4);
        check("nom_und", r_und[8], 0);

        // Stall of 3 cycles mid-burst, len 2
        burst_len = 6'd2;
        set_pats(3, 3);
        run(10);
        for (int k = 1; k < 10; k++) begin
            check($sformatf("stl_din%0d", k), r_din[k], stl_din[k]);
            check($sformatf("stl_tin%0d", k), r_tin[k], stl_tin[k]);
            check($sformatf("stl_done%0d", k), r_done[k], stl_done[k]);
        end
        check("stl_und2", r_und[2], 0);
        check("stl_und3", r_und[3], 1);
        check("stl_und9", r_und[9], 1);
        check("stl_acc", n_acc, 2);

        // Wrap: len 0 means 64 beats; extra starts mid-burst and in POST are ignored
        burst_len = 6'd0;
        set_pats(0, 0);
        st_pat[10] = 1'b1;
        st_pat[40] = 1'b1;
        st_pat[66] = 1'b1;
        run(69);
        check("wrp_und0", r_und[0], 0);
        check("wrp_acc", n_acc, 64);
        check("wrp_din65", r_din[65], dat_fn(63));
        check("wrp_rdy64", r_rdy[64], 1);
        check("wrp_rdy65", r_rdy[65], 0);
        check("wrp_tin66", r_tin[66], 32'h0);
        check("wrp_done66", r_done[66], 0);
        check("wrp_tin67", r_tin[67], 32'hFFFFFFFF);
        check("wrp_done67", r_done[67], 1);
        check("wrp_busy68", r_busy[68], 0);

        // Reset after 2 of 8 beats
        burst_len = 6'd8;
        set_pats(0, 0);
        run(4);
        check("abt_acc", n_acc, 2);
        check("abt_tin_pre", tin, 32'h0);
        rst = 1'b1;
        tick();
        check("abt_tin", tin, 32'hFFFFFFFF);
        check("abt_busy", busy, 0);
        check("abt_done", done, 0);
        check("abt_din", din, 32'h0);
        check("abt_rdy", wr_if.wr_ready, 0);
        rst = 1'b0;
        tick();
        check("abt_done2", done, 0);
        burst_len = 6'd1;
        set_pats(0, 0);
        run(5);
        check("abt2_din2", r_din[2], 32'h11111111);
        check("abt2_tin3", r_tin[3], 32'h0);
        check("abt2_tin4", r_tin[4], 32'hFFFFFFFF);
        check("abt2_done4", r_done[4], 1);
        check("abt2_acc", n_acc, 1);

`ifdef OSERDES_MEM_BURST_DQS_EN
        // Strobe lane, len 3
        burst_len = 6'd3;
        set_pats(0, 0);
        run(7);
        check("dqs_din1", r_qdin[1], 4'b0000);
        check("dqs_din2", r_qdin[2], 4'b1010);
        check("dqs_din3", r_qdin[3], 4'b1010);
        check("dqs_din4", r_qdin[4], 4'b1010);
        check("dqs_din5", r_qdin[5], 4'b0000);
        check("dqs_tin0", r_qtin[0], 4'b1111);
        for (int k = 1; k < 6; k++) check($sformatf("dqs_tin%0d", k), r_qtin[k], 4'b0000);
        check("dqs_tin6", r_qtin[6], 4'b1111);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
